// File: rtl/ps2_device_emulator_if.sv
// Key-event handshake and PS/2 line bundle shared by the keyboard emulator and its driver.
interface ps2_device_emulator_if;
    logic [7:0] KEY_CODE;
    logic       KEY_EXT;
    logic       KEY_RELEASE;
    logic       KEY_VALID;
    logic       KEY_READY;
    logic       HOST_INHIBIT;
    logic       PS2_CLK;
    logic       PS2_DATA;
    logic       BUSY;
    logic       OVERFLOW;

    modport master (
        output KEY_CODE, KEY_EXT, KEY_RELEASE, KEY_VALID, HOST_INHIBIT,
        input  KEY_READY, PS2_CLK, PS2_DATA, BUSY, OVERFLOW
    );

    modport slave (
        input  KEY_CODE, KEY_EXT, KEY_RELEASE, KEY_VALID, HOST_INHIBIT,
        output KEY_READY, PS2_CLK, PS2_DATA, BUSY, OVERFLOW
    );
endinterface

// File: rtl/ps2_device_emulator.sv
// PS/2 keyboard-side transmitter: buffers key events in a FIFO and serialises each as
// [E0] [F0] code in 11-bit frames, honouring host inhibit with per-byte retransmission.
module ps2_device_emulator #(
    parameter int CLK_DIV    = 2048,
    parameter int DATA_SETUP = 1000,
    parameter int GAP_CYCLES = 4096,
    parameter int FIFO_DEPTH = 8,
    parameter int PARITY_ODD = 1
) (
    input  logic                 CLK100MHZ,
    input  logic                 RESET,
    ps2_device_emulator_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam logic [PW:0]   DEPTH_L = (PW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_L   = CW'(CLK_DIV);
    localparam logic [CW-1:0] SETUP_L = CW'(DATA_SETUP);
    localparam logic [GW-1:0] GAP_L   = GW'(GAP_CYCLES);

    typedef enum logic [2:0] {IDLE, START, HIGH, LOW, GAP} state_t;

    logic [9:0]    mem [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [9:0]    head;
    logic          push, pop, empty, abort, cur_bit;
    logic          key_ready_r, overflow_r, busy_r, ps2_clk_r, ps2_data_r;
    state_t        state;
    logic [CW-1:0] half_cnt;
    logic [GW-1:0] gap_cnt;
    logic [3:0]    bit_idx;
    logic [1:0]    stage;
    logic          pend;
    logic [8:0]    cur;

    function automatic logic [7:0] stage_byte(input logic [1:0] stg, input logic [7:0] code);
        case (stg)
            2'd0:    return 8'hE0;
            2'd1:    return 8'hF0;
            default: return code;
        endcase
    endfunction

    // Frame bit order: start(0), D0..D7, parity, stop(1).
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic [3:0] k;
        k = idx - 4'd1;
        if (idx == 4'd0)       return 1'b0;
        else if (idx <= 4'd8)  return b[k[2:0]];
        else if (idx == 4'd9)  return (PARITY_ODD != 0) ? ~^b : ^b;
        else                   return 1'b1;
    endfunction

    assign empty   = (wr_ptr == rd_ptr);
    assign head    = mem[rd_ptr[PW-1:0]];
    assign push    = bus.KEY_VALID && key_ready_r;
    assign pop     = (state == IDLE) && !bus.HOST_INHIBIT && !pend && !empty;
    assign wr_nxt  = wr_ptr + (PW + 1)'(push);
    assign rd_nxt  = rd_ptr + (PW + 1)'(pop);
    assign cur_bit = frame_bit(stage_byte(stage, cur[7:0]), bit_idx);
    // Once the 11th falling edge has happened the byte is delivered and cannot be aborted.
    assign abort   = bus.HOST_INHIBIT &&
                     ((state == START) || (state == HIGH) ||
                      ((state == LOW) && (bit_idx != 4'd10)));

    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            key_ready_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            wr_ptr      <= wr_nxt;
            rd_ptr      <= rd_nxt;
            key_ready_r <= ((wr_nxt - rd_nxt) != DEPTH_L);
            if (bus.KEY_VALID && !key_ready_r)
                overflow_r <= 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (push)
            mem[wr_ptr[PW-1:0]] <= {bus.KEY_EXT, bus.KEY_RELEASE, bus.KEY_CODE};
        if (pop)
            cur <= head[8:0];
    end

    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            half_cnt   <= '0;
            gap_cnt    <= '0;
            bit_idx    <= '0;
            stage      <= '0;
            pend       <= 1'b0;
            ps2_clk_r  <= 1'b1;
            ps2_data_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            busy_r <= (state != IDLE) || !empty || pend;
            if (abort) begin
                // Release clock first; data follows a cycle later so the lines never move together.
                state   <= GAP;
                gap_cnt <= GW'(1);
                if (!ps2_clk_r) ps2_clk_r  <= 1'b1;
                else            ps2_data_r <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        ps2_clk_r  <= 1'b1;
                        ps2_data_r <= 1'b1;
                        if (!bus.HOST_INHIBIT && (pend || !empty)) begin
                            if (!pend) begin
                                stage <= head[9] ? 2'd0 : (head[8] ? 2'd1 : 2'd2);
                                pend  <= 1'b1;
                            end
                            state    <= START;
                            half_cnt <= CW'(1);
                            bit_idx  <= '0;
                        end
                    end
                    START, HIGH: begin
                        if (half_cnt == SETUP_L)
                            ps2_data_r <= cur_bit;
                        if (half_cnt == DIV_L) begin
                            state     <= LOW;
                            ps2_clk_r <= 1'b0;
                            half_cnt  <= CW'(1);
                        end else begin
                            half_cnt <= half_cnt + CW'(1);
                        end
                    end
                    LOW: begin
                        if (half_cnt == DIV_L) begin
                            ps2_clk_r <= 1'b1;
                            half_cnt  <= CW'(1);
                            if (bit_idx == 4'd10) begin
                                state   <= GAP;
                                gap_cnt <= GW'(1);
                                case (stage)
                                    2'd0:    stage <= cur[8] ? 2'd1 : 2'd2;
                                    2'd1:    stage <= 2'd2;
                                    default: pend  <= 1'b0;
                                endcase
                            end else begin
                                bit_idx <= bit_idx + 4'd1;
                                state   <= HIGH;
                            end
                        end else begin
                            half_cnt <= half_cnt + CW'(1);
                        end
                    end
                    GAP: begin
                        ps2_clk_r  <= 1'b1;
                        ps2_data_r <= 1'b1;
                        if (bus.HOST_INHIBIT) begin
                            gap_cnt <= GW'(1);
                        end else if (gap_cnt == GAP_L) begin
                            if (pend) begin
                                state    <= START;
                                half_cnt <= CW'(1);
                                bit_idx  <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + GW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.KEY_READY = key_ready_r;
    assign bus.PS2_CLK   = ps2_clk_r;
    assign bus.PS2_DATA  = ps2_data_r;
    assign bus.BUSY      = busy_r;
    assign bus.OVERFLOW  = overflow_r;
endmodule

// File: tb/tb_ps2_device_emulator.sv
// Directed bench for ps2_device_emulator: decodes frames on the PS/2 lines and checks them
// against hand-computed frames, gaps, FIFO flow control, inhibit retransmission and reset.
module tb_ps2_device_emulator;
    localparam int CLK_DIV    = 8;
    localparam int DATA_SETUP = 3;
    localparam int GAP_CYCLES = 20;
    localparam int FIFO_DEPTH = 8;

    // Frames packed {stop, parity, byte, start}; parity bits worked out by hand (odd parity).
    localparam logic [10:0] F29 = {1'b1, 1'b0, 8'h29, 1'b0};
    localparam logic [10:0] FF0 = {1'b1, 1'b1, 8'hF0, 1'b0};
    localparam logic [10:0] FE0 = {1'b1, 1'b0, 8'hE0, 1'b0};
    localparam logic [10:0] F75 = {1'b1, 1'b0, 8'h75, 1'b0};
    localparam logic [10:0] F5A = {1'b1, 1'b1, 8'h5A, 1'b0};

    logic CLK100MHZ = 1'b0;
    logic RESET     = 1'b1;
    ps2_device_emulator_if bus();

    ps2_device_emulator #(
        .CLK_DIV(CLK_DIV), .DATA_SETUP(DATA_SETUP), .GAP_CYCLES(GAP_CYCLES),
        .FIFO_DEPTH(FIFO_DEPTH), .PARITY_ODD(1)
    ) dut (
        .CLK100MHZ(CLK100MHZ),
        .RESET(RESET),
        .bus(bus)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    int n_cmp = 0;
    int n_err = 0;

    // Line monitor: records data at every PS2_CLK falling edge and counts clock transitions.
    logic prev_clk = 1'b1;
    bit   fall_q[$];
    int   fall_t[$];
    int   cyc = 0;
    int   clk_edges = 0;
    always @(negedge CLK100MHZ) begin
        cyc <= cyc + 1;
        if (prev_clk && !bus.PS2_CLK) begin
            fall_q.push_back(bus.PS2_DATA);
            fall_t.push_back(cyc);
        end
        if (prev_clk !== bus.PS2_CLK) clk_edges <= clk_edges + 1;
        prev_clk <= bus.PS2_CLK;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] frame_at(input int base);
        logic [10:0] f;
        for (int i = 0; i < 11; i++)
            f[i] = (base + i < fall_q.size()) ? fall_q[base + i] : 1'bx;
        return f;
    endfunction

    task automatic wait_falls(input int n, input int budget, input string tag);
        int k = 0;
        while (fall_q.size() < n && k < budget) begin
            @(posedge CLK100MHZ);
            k++;
        end
        check({tag, "_falls_seen"}, 32'(fall_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int k = 0;
        #1;
        while (bus.BUSY !== 1'b0 && k < budget) begin
            @(posedge CLK100MHZ);
            #1;
            k++;
        end
        check({tag, "_busy_low"}, 32'(bus.BUSY), 32'd0);
    endtask

    task automatic push_evt(input logic ext, input logic rel, input logic [7:0] code);
        int k = 0;
        @(negedge CLK100MHZ);
        while (!bus.KEY_READY && k < 1000) begin
            @(negedge CLK100MHZ);
            k++;
        end
        bus.KEY_EXT     = ext;
        bus.KEY_RELEASE = rel;
        bus.KEY_CODE    = code;
        bus.KEY_VALID   = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        bus.KEY_VALID = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int e0;
        logic [7:0] p4;
        bus.KEY_CODE     = 8'h00;
        bus.KEY_EXT      = 1'b0;
        bus.KEY_RELEASE  = 1'b0;
        bus.KEY_VALID    = 1'b0;
        bus.HOST_INHIBIT = 1'b0;

        // Reset state
        repeat (3) @(posedge CLK100MHZ);
        #1;
        check("rst_clk",   32'(bus.PS2_CLK),   32'd1);
        check("rst_data",  32'(bus.PS2_DATA),  32'd1);
        check("rst_ready", 32'(bus.KEY_READY), 32'd0);
        check("rst_busy",  32'(bus.BUSY),      32'd0);
        check("rst_ovf",   32'(bus.OVERFLOW),  32'd0);
        @(negedge CLK100MHZ);
        RESET = 1'b0;
        @(posedge CLK100MHZ);
        #1;
        check("ready_after_rst", 32'(bus.KEY_READY), 32'd1);

        // 1: single make code 29h
        base = fall_q.size();
        push_evt(1'b0, 1'b0, 8'h29);
        wait_falls(base + 11, 1000, "t1");
        check("t1_frame", 32'(frame_at(base)), 32'(F29));
        check("t1_bit_period", 32'(fall_t[base + 1] - fall_t[base]), 32'(2 * CLK_DIV));
        wait_idle(500, "t1");
        check("t1_count", 32'(fall_q.size() - base), 32'd11);

        // 2: break code F0 29
        base = fall_q.size();
        push_evt(1'b0, 1'b1, 8'h29);
        wait_falls(base + 22, 2000, "t2");
        check("t2_frame0", 32'(frame_at(base)),      32'(FF0));
        check("t2_frame1", 32'(frame_at(base + 11)), 32'(F29));
        check("t2_gap", 32'(fall_t[base + 11] - fall_t[base + 10]), 32'(2 * CLK_DIV + GAP_CYCLES));
        wait_idle(500, "t2");

        // 3: extended break E0 F0 75, one FIFO entry
        base = fall_q.size();
        push_evt(1'b1, 1'b1, 8'h75);
        wait_falls(base + 33, 3000, "t3");
        check("t3_frame0", 32'(frame_at(base)),      32'(FE0));
        check("t3_frame1", 32'(frame_at(base + 11)), 32'(FF0));
        check("t3_frame2", 32'(frame_at(base + 22)), 32'(F75));
        wait_idle(500, "t3");
        check("t3_count", 32'(fall_q.size() - base), 32'd33);

        // 4: fill FIFO while inhibited, then overflow
        base = fall_q.size();
        bus.HOST_INHIBIT = 1'b1;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (i == FIFO_DEPTH - 1)
                check("t4_ready_before_last", 32'(bus.KEY_READY), 32'd1);
            push_evt(1'b0, 1'b0, 8'h10 + 8'(i));
        end
        check("t4_ready_full", 32'(bus.KEY_READY), 32'd0);
        check("t4_busy_inhibited", 32'(bus.BUSY), 32'd1);
        @(negedge CLK100MHZ);
        bus.KEY_CODE  = 8'h18;
        bus.KEY_VALID = 1'b1;
        @(posedge CLK100MHZ);
        #1;
        bus.KEY_VALID = 1'b0;
        @(posedge CLK100MHZ);
        #1;
        check("t4_overflow", 32'(bus.OVERFLOW), 32'd1);
        repeat (20) @(posedge CLK100MHZ);
        check("t4_no_tx_inhibited", 32'(fall_q.size() - base), 32'd0);
        bus.HOST_INHIBIT = 1'b0;
        p4 = 8'b1001_0110;
        wait_falls(base + 11 * FIFO_DEPTH, 4000, "t4");
        for (int i = 0; i < FIFO_DEPTH; i++)
            check($sformatf("t4_frame%0d", i), 32'(frame_at(base + 11 * i)),
                  32'({1'b1, p4[i], 8'h10 + 8'(i), 1'b0}));
        wait_idle(1000, "t4");
        check("t4_ninth_dropped", 32'(fall_q.size() - base), 32'(11 * FIFO_DEPTH));
        check("t4_ready_back", 32'(bus.KEY_READY), 32'd1);

        // 5: inhibit after 5th falling edge, byte resent from start bit
        base = fall_q.size();
        push_evt(1'b0, 1'b0, 8'h29);
        wait_falls(base + 5, 1000, "t5a");
        #1;
        bus.HOST_INHIBIT = 1'b1;
        repeat (3) @(posedge CLK100MHZ);
        #1;
        check("t5_clk_high",  32'(bus.PS2_CLK),  32'd1);
        check("t5_data_high", 32'(bus.PS2_DATA), 32'd1);
        repeat (40) @(posedge CLK100MHZ);
        check("t5_held", 32'(fall_q.size() - base), 32'd5);
        bus.HOST_INHIBIT = 1'b0;
        wait_falls(base + 16, 1000, "t5b");
        check("t5_resent", 32'(frame_at(base + 5)), 32'(F29));
        wait_idle(500, "t5");
        check("t5_count", 32'(fall_q.size() - base), 32'd16);

        // 6: reset mid-frame
        base = fall_q.size();
        push_evt(1'b0, 1'b0, 8'h29);
        push_evt(1'b0, 1'b0, 8'h29);
        wait_falls(base + 3, 1000, "t6a");
        #2;
        RESET = 1'b1;
        #1;
        check("t6_clk",   32'(bus.PS2_CLK),   32'd1);
        check("t6_data",  32'(bus.PS2_DATA),  32'd1);
        check("t6_busy",  32'(bus.BUSY),      32'd0);
        check("t6_ready", 32'(bus.KEY_READY), 32'd0);
        check("t6_ovf",   32'(bus.OVERFLOW),  32'd0);
        repeat (3) @(posedge CLK100MHZ);
        @(negedge CLK100MHZ);
        RESET = 1'b0;
        @(negedge CLK100MHZ);
        e0 = clk_edges;
        base = fall_q.size();
        repeat (300) @(posedge CLK100MHZ);
        #1;
        check("t6_no_edges", 32'(clk_edges - e0), 32'd0);
        check("t6_idle_busy", 32'(bus.BUSY), 32'd0);
        check("t6_idle_ready", 32'(bus.KEY_READY), 32'd1);
        push_evt(1'b0, 1'b0, 8'h5A);
        wait_falls(base + 11, 1000, "t6b");
        check("t6_new_frame", 32'(frame_at(base)), 32'(F5A));
        wait_idle(500, "t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
